// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 result-bus router.
package demux_pkg;

  localparam int unsigned NUM_CANALES = 4;

  typedef enum logic [1:0] {CH_A, CH_B, CH_C, CH_D} canal_t;

  typedef enum logic {EMPTY, FULL} slot_state_t;

endpackage

// File: rtl/demultiplexor4_router_if.sv
// Router bus: one upstream valid/ready stream and four downstream channels.
interface demultiplexor4_router_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  import demux_pkg::*;

  logic [WIDTH-1:0]                        datoInput;
  logic [1:0]                              selDato;
  logic                                    validInput;
  logic                                    readyInput;
  logic [NUM_CANALES-1:0][WIDTH-1:0]       datoOutput;
  logic [NUM_CANALES-1:0]                  validOutput;
  logic [NUM_CANALES-1:0]                  readyOutput;
  logic [NUM_CANALES-1:0][CNT_W-1:0]       cuenta;
  logic                                    busy;

  modport master (
    output datoInput, selDato, validInput, readyOutput,
    input  readyInput, datoOutput, validOutput, cuenta, busy
  );

  modport slave (
    input  datoInput, selDato, validInput, readyOutput,
    output readyInput, datoOutput, validOutput, cuenta, busy
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready handshake and delivery counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dato,
  input  logic             ready,
  output logic             valid,
  output logic             libre_c,
  output logic [WIDTH-1:0] dato_q,
  output logic [CNT_W-1:0] cuenta
);

  slot_state_t state, state_next;
  logic        drain;

  assign valid   = (state == FULL);
  assign drain   = valid & ready;
  // Slot can take a word when empty or when its held word leaves this same edge.
  assign libre_c = ~valid | ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (load) state_next = FULL;
      FULL:    if (drain && !load) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Data is held after drain; only a new load replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dato_q <= '0;
      cuenta <= '0;
    end else begin
      if (load)  dato_q <= dato;
      if (drain) cuenta <= cuenta + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demultiplexor4_router.sv
// Steers one valid/ready word stream to one of four buffered consumer channels.
module demultiplexor4_router
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  demultiplexor4_router_if.slave   bus
);

  canal_t                 canal;
  logic                   acc;
  logic [NUM_CANALES-1:0] load;
  logic [NUM_CANALES-1:0] libre;
  logic [NUM_CANALES-1:0] valid;

  // Only the selected channel gates the input; readyOutput feeds straight through.
  assign canal          = canal_t'(bus.selDato);
  assign bus.readyInput = libre[canal];
  assign acc            = bus.validInput & bus.readyInput;

  for (genvar i = 0; i < NUM_CANALES; i++) begin : g_slot
    assign load[i] = acc && (canal == canal_t'(2'(i)));

    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .dato    (bus.datoInput),
      .ready   (bus.readyOutput[i]),
      .valid   (valid[i]),
      .libre_c (libre[i]),
      .dato_q  (bus.datoOutput[i]),
      .cuenta  (bus.cuenta[i])
    );
  end

  assign bus.validOutput = valid;
  assign bus.busy        = |valid;

endmodule

// File: tb/tb_demultiplexor4_router.sv
// Scoreboard bench for demultiplexor4_router: per-channel expected-word queues and counters.
module tb_demultiplexor4_router;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NCH   = 4;

  logic clk;
  logic rst;

  demultiplexor4_router_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demultiplexor4_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [WIDTH-1:0] sb [NCH][$];
  logic [CNT_W-1:0] exp_cnt [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      sb[i].delete();
      exp_cnt[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] s);
    bus.datoInput  = d;
    bus.selDato    = s;
    bus.validInput = 1'b1;
    tick();
    bus.validInput = 1'b0;
  endtask

  // Monitor on the falling edge: what is visible now is what the next rising edge commits.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_d;
    logic             exp_rdy;
    int               sel;
    if (!rst) begin
      sel     = int'(bus.selDato);
      exp_rdy = (sb[sel].size() == 0) || bus.readyOutput[sel];
      check("ready_in", 64'(bus.readyInput), 64'(exp_rdy));
      check("busy", 64'(bus.busy), 64'((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0));
      for (int i = 0; i < NCH; i++) begin
        check($sformatf("valid%0d", i), 64'(bus.validOutput[i]), 64'(sb[i].size() != 0));
        check($sformatf("cuenta%0d", i), 64'(bus.cuenta[i]), 64'(exp_cnt[i]));
        if (bus.validOutput[i] && bus.readyOutput[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("occupancy%0d", i), 64'(sb[i].size()), 64'd1);
          end else begin
            exp_d = sb[i].pop_front();
            check($sformatf("dato%0d", i), 64'(bus.datoOutput[i]), 64'(exp_d));
          end
          exp_cnt[i] = exp_cnt[i] + CNT_W'(1);
        end
      end
      if (bus.validInput && exp_rdy) sb[sel].push_back(bus.datoInput);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    rst             = 1'b1;
    bus.validInput  = 1'b0;
    bus.datoInput   = '0;
    bus.selDato     = 2'd0;
    bus.readyOutput = 4'b0000;
    #3;
    check("rst_valid", 64'(bus.validOutput), 64'd0);
    check("rst_cuenta", 64'(bus.cuenta), 64'd0);
    check("rst_dato", 64'(bus.datoOutput[0]), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ready_in", 64'(bus.readyInput), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-cycle while channel B holds a word.
    send(32'hB, 2'd1);
    check("b_full", 64'(bus.validOutput), 64'b0010);
    check("b_dato", 64'(bus.datoOutput[1]), 64'hB);
    #2 rst = 1'b1;
    model_clear();
    #1;
    check("async_valid", 64'(bus.validOutput), 64'd0);
    check("async_cuenta", 64'(bus.cuenta), 64'd0);
    check("async_busy", 64'(bus.busy), 64'd0);
    check("async_dato", 64'(bus.datoOutput[1]), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("release_ready_in", 64'(bus.readyInput), 64'd1);

    // Routing sweep, all consumers ready.
    bus.readyOutput = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      send(WIDTH'(k + 1), 2'(k));
      check("sweep_valid", 64'(bus.validOutput), 64'(4'b0001 << k));
      check("sweep_dato", 64'(bus.datoOutput[k]), 64'(k + 1));
    end
    tick();
    tick();
    check("sweep_cuenta", 64'(bus.cuenta), 64'({8'd1, 8'd1, 8'd1, 8'd1}));

    // Backpressure on A must not block B.
    bus.readyOutput = 4'b1110;
    send(32'd5, 2'd0);
    check("bp_a_dato", 64'(bus.datoOutput[0]), 64'd5);
    bus.datoInput  = 32'd6;
    bus.selDato    = 2'd0;
    bus.validInput = 1'b1;
    #1;
    check("bp_ready_low", 64'(bus.readyInput), 64'd0);
    tick();
    check("bp_a_hold", 64'(bus.datoOutput[0]), 64'd5);
    check("bp_a_valid", 64'(bus.validOutput[0]), 64'd1);
    bus.selDato = 2'd1;
    #1;
    check("bp_ready_b", 64'(bus.readyInput), 64'd1);
    tick();
    bus.validInput = 1'b0;
    check("bp_b_dato", 64'(bus.datoOutput[1]), 64'd6);
    bus.readyOutput = 4'b1111;
    tick();
    tick();

    // Streaming to C at full rate.
    for (int k = 0; k < 10; k++) begin
      bus.datoInput  = WIDTH'(100 + k);
      bus.selDato    = 2'd2;
      bus.validInput = 1'b1;
      #1;
      check("stream_ready", 64'(bus.readyInput), 64'd1);
      tick();
    end
    bus.validInput = 1'b0;
    tick();
    tick();
    check("stream_cuenta_c", 64'(bus.cuenta[2]), 64'd11);

    // 255 more deliveries on D take its counter from 1 around to 0.
    for (int k = 0; k < 255; k++) send(WIDTH'(32'h1000 + k), 2'd3);
    tick();
    tick();
    check("wrap_cuenta", 64'(bus.cuenta), 64'({8'd0, 8'd11, 8'd2, 8'd2}));

    // Concurrent drain of A and D with a new fill of A.
    bus.readyOutput = 4'b0000;
    send(32'hA1, 2'd0);
    send(32'hD1, 2'd3);
    check("conc_full", 64'(bus.validOutput), 64'b1001);
    bus.readyOutput = 4'b1001;
    send(32'hA2, 2'd0);
    bus.readyOutput = 4'b0000;
    check("conc_valid", 64'(bus.validOutput), 64'b0001);
    check("conc_a_dato", 64'(bus.datoOutput[0]), 64'hA2);
    check("conc_cuenta_a", 64'(bus.cuenta[0]), 64'd3);
    check("conc_cuenta_d", 64'(bus.cuenta[3]), 64'd1);
    check("conc_d_hold", 64'(bus.datoOutput[3]), 64'hD1);

    bus.readyOutput = 4'b1111;
    repeat (3) tick();
    check("final_valid", 64'(bus.validOutput), 64'd0);
    check("final_busy", 64'(bus.busy), 64'd0);
    check("final_cuenta", 64'(bus.cuenta), 64'({8'd1, 8'd11, 8'd2, 8'd4}));
    check("final_sb_empty", 64'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demultiplexor4_router.md
Name: demultiplexor4_router

Overview:
- 1-to-4 steering counterpart of the 4:1 data multiplexor: one WIDTH-bit input stream with valid/ready, routed by a 2-bit select to one of four output channels.
- Each output channel has its own one-entry holding register with a valid/ready handshake.
- Sits between the datapath result bus and four downstream consumers: register write-back, memory store, video/sprite unit, I/O.
- Keeps per-channel 8-bit transfer counters for debug.

Parameters:
- WIDTH, 32, data width of input and each output channel.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- datoInput  input  WIDTH  input data word.
- selDato  input  2  destination channel: 00=A, 01=B, 10=C, 11=D.
- validInput  input  1  datoInput/selDato are valid this cycle.
- readyInput  output  1  router accepts the word this cycle.
- datoOutput  output  4 x WIDTH (packed [3:0][WIDTH-1:0])  per-channel held data.
- validOutput  output  4  per-channel holding register full.
- readyOutput  input  4  per-channel consumer accepts.
- cuenta  output  4 x CNT_W (packed)  per-channel count of words delivered downstream.
- busy  output  1  OR of validOutput.

Behaviour:
- Reset (async, rst=1): validOutput=0000, datoOutput all 0, cuenta all 0, busy=0. readyInput is combinational and therefore 1 during reset release. Any word in flight is discarded. Reset mid-transfer clears holding registers in the same instant, with no clock needed.
- Accept: acc = validInput & readyInput.
- readyInput (combinational): !validOutput[selDato] | readyOutput[selDato]. It depends only on the selected channel; other channels being full never stall the input.
- Fill: on a clk edge with acc, channel selDato loads datoInput and sets validOutput[selDato]=1. Latency is one cycle, input to output-valid.
- Drain: on a clk edge with validOutput[i] & readyOutput[i], channel i clears valid and increments cuenta[i]. The counter wraps at 2^CNT_W-1 -> 0. datoOutput[i] holds its last value after drain and is not cleared.
- Simultaneous drain and fill of the same channel: new word loads, valid stays 1, cuenta increments. This gives full throughput of 1 word/cycle per channel.
- Simultaneous fill of channel i and drain of channel j (i≠j): both take effect independently.
- All four channels may drain in the same cycle. Every counter updates independently.
- validInput=0: no state change on the input side. selDato is don't-care, but readyInput still reflects it.
- Output stability: while validOutput[i]=1 and readyOutput[i]=0, datoOutput[i] must not change.
- Per-channel state machine, 2 states:
  - EMPTY -> FULL on fill.
  - FULL -> EMPTY on drain without fill.
  - FULL -> FULL on drain with fill, or when neither occurs.
  - EMPTY + readyOutput with no fill -> stays EMPTY, no count.
- No combinational path from validInput to validOutput. The only combinational path is readyOutput -> readyInput.

Decomposition:
- Package demux_pkg:
  - typedef enum logic [1:0] {CH_A, CH_B, CH_C, CH_D} canal_t.
  - localparam NUM_CANALES=4.
- Sub-module demux_slot, instantiated 4 times via generate. It contains the one-entry register, the valid flag, the counter and the ready logic.
  - Ports: clk, rst, load, dato, valid, ready, cuenta.
  - Parameters: WIDTH, CNT_W.
- The top level decodes selDato into one-hot load and muxes readyInput.

Test Plan:
- Reset then idle, with rst asserted mid-cycle while channel B is full (data 32'hB):
  - validOutput=0000, cuenta all 0 immediately, without waiting for a clk edge.
  - readyInput=1 after release.
- Routing sweep:
  - Inputs 1,2,3,4 with selDato 00,01,10,11 on consecutive cycles, readyOutput=1111.
  - Each channel shows valid for exactly 1 cycle, one cycle after acceptance, with datoOutput = 1, 2, 3, 4 respectively.
  - cuenta = 1,1,1,1.
- Backpressure:
  - readyOutput[A]=0, send 5 to A. A stays valid=1 with data 5.
  - Second word 6 to A -> readyInput=0, A still holds 5.
  - Switch selDato=01 -> readyInput=1, and B receives 6.
- Streaming: 10 back-to-back words to C with readyOutput[C]=1 -> readyInput stays 1 every cycle, C delivers 10 in-order words, cuenta[C]=10.
- Counter wrap: 256 deliveries on D (CNT_W=8) -> cuenta[D] returns to 0, other counters unchanged.
- Concurrent drain/fill: A and D full, readyOutput=1001, new word to A in the same cycle:
  - A holds the new word, valid=1.
  - D goes empty.
  - cuenta[A] and cuenta[D] both +1.
